bcd_to_bin_seq: RTL and testbench

- Sequential BCD-to-binary converter. It is the reverse path of the display's binary-to-BCD decoder.
- Takes DIGITS packed BCD digits (keypad/decimal entry for the RPN 8-bit ALU) and produces an OUT_W-bit binary operand.
- Uses reverse double-dabble (shift right, subtract 3 from any nibble >= 8), one iteration per clock.
- Start/busy/done handshake, with overflow and invalid-digit flags.

---
 rtl/bcd_to_bin_seq_if.sv | 46 ++++
 rtl/bcd_to_bin_seq.sv | 197 +++++++++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_to_bin_seq_if.sv
// ---------------------------------------------------------------------------
// bcd_to_bin_seq_if
// Handshake and data bundle between a requester (master) and the sequential
// BCD-to-binary converter (slave).
//
// Signals:
//   start     master->slave  request a conversion of bcd_in
//   bcd_in    master->slave  packed BCD operand, 4*DIGITS bits, unit digit low
//   busy      slave->master  high while the converter iterates
//   done      slave->master  one-cycle pulse, result valid
//   bin_out   slave->master  OUT_W-bit binary result, held until next start
//   ovf       slave->master  true value did not fit in OUT_W bits
//   err_digit slave->master  a captured nibble was greater than 9
// ---------------------------------------------------------------------------
interface bcd_to_bin_seq_if #(
    parameter int DIGITS = 3,
    parameter int OUT_W  = 8
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic [OUT_W-1:0]      bin_out;
    logic                  ovf;
    logic                  err_digit;

    modport master (
        output start,
        output bcd_in,
        input  busy,
        input  done,
        input  bin_out,
        input  ovf,
        input  err_digit
    );

    modport slave (
        input  start,
        input  bcd_in,
        output busy,
        output done,
        output bin_out,
        output ovf,
        output err_digit
    );
endinterface

// File: rtl/bcd_to_bin_seq.sv
// ---------------------------------------------------------------------------
// bcd_to_bin_seq
// Sequential BCD-to-binary converter using reverse double-dabble: each clock
// the {bcd, bin} pair is shifted right by one and every BCD nibble that ends
// up >= 8 has 3 subtracted. After 4*DIGITS iterations bin holds the value.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; aborts any conversion
//   bus    bcd_to_bin_seq_if.slave (start, bcd_in, busy, done, bin_out,
//          ovf, err_digit)
//
// Optional feature macro: BCD2BIN_SAT_EN
//   defined   : overflowing results saturate bin_out to all ones
//   undefined : overflowing results are truncated to the low OUT_W bits
// ovf is raised in both builds.
// ---------------------------------------------------------------------------
module bcd_to_bin_seq #(
    parameter int DIGITS = 3,
    parameter int OUT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    bcd_to_bin_seq_if.slave  bus
);

    localparam int BW    = 4 * DIGITS;
    localparam int CNT_W = (BW > 1) ? $clog2(BW) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state_q;
    logic [BW-1:0]       bcd_q;
    logic [BW-1:0]       bin_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                busy_q;
    logic                done_q;
    logic [OUT_W-1:0]    bin_out_q;
    logic                ovf_q;
    logic                err_q;

    logic [BW-1:0]       bcd_d;
    logic [BW-1:0]       bin_d;
    logic                in_bad_s;
    logic                fin_ovf_s;
    logic [OUT_W-1:0]    fin_bin_s;
    logic                last_iter_s;

    // True when any nibble of the operand is not a decimal digit.
    function automatic logic any_bad_digit(input logic [BW-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end else begin
                bad = bad;
            end
        end
        return bad;
    endfunction

    // Reverse-dabble correction: a nibble that received a bit from its
    // upper neighbour (value >= 8) carried 10 into this place instead of 16.
    function automatic logic [BW-1:0] dabble_fix(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd8) begin
                r[4*i +: 4] = v[4*i +: 4] - 4'd3;
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Any bit above the output width set means the value does not fit.
    // With OUT_W >= BW the loop is empty and the result is constant 0.
    function automatic logic high_bits_set(input logic [BW-1:0] v);
        logic r;
        r = 1'b0;
        for (int i = OUT_W; i < BW; i++) begin
            r = r | v[i];
        end
        return r;
    endfunction

    // Low OUT_W bits of the result, zero-extended when OUT_W > BW.
    function automatic logic [OUT_W-1:0] low_bits(input logic [BW-1:0] v);
        logic [OUT_W-1:0] r;
        r = {OUT_W{1'b0}};
        for (int i = 0; i < OUT_W; i++) begin
            if (i < BW) begin
                r[i] = v[i];
            end else begin
                r[i] = 1'b0;
            end
        end
        return r;
    endfunction

    // One reverse double-dabble step on the current shift register.
    always_comb begin
        bin_d = {bcd_q[0], bin_q[BW-1:1]};
        bcd_d = dabble_fix({1'b0, bcd_q[BW-1:1]});
    end

    // Operand validity, end-of-iteration detect and final result shaping.
    always_comb begin
        in_bad_s    = any_bad_digit(bus.bcd_in);
        last_iter_s = (cnt_q == CNT_W'(BW - 1));
        fin_ovf_s   = high_bits_set(bin_d);
`ifdef BCD2BIN_SAT_EN
        if (fin_ovf_s) begin
            fin_bin_s = {OUT_W{1'b1}};
        end else begin
            fin_bin_s = low_bits(bin_d);
        end
`else
        fin_bin_s   = low_bits(bin_d);
`endif
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bcd_q     <= {BW{1'b0}};
            bin_q     <= {BW{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bin_out_q <= {OUT_W{1'b0}};
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        bcd_q <= bus.bcd_in;
                        bin_q <= {BW{1'b0}};
                        cnt_q <= {CNT_W{1'b0}};
                        ovf_q <= 1'b0;
                        if (in_bad_s) begin
                            // Invalid operand: report immediately, no iterations.
                            state_q   <= ST_DONE;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            err_q     <= 1'b1;
                            bin_out_q <= {OUT_W{1'b0}};
                        end else begin
                            // bin_out keeps the previous result until DONE.
                            state_q <= ST_SHIFT;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                            err_q   <= 1'b0;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    bcd_q <= bcd_d;
                    bin_q <= bin_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_iter_s) begin
                        state_q   <= ST_DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        bin_out_q <= fin_bin_s;
                        ovf_q     <= fin_ovf_s;
                    end else begin
                        state_q <= ST_SHIFT;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.bin_out   = bin_out_q;
    assign bus.ovf       = ovf_q;
    assign bus.err_digit = err_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq (DIGITS=3, OUT_W=8).
module tb_bcd_to_bin_seq;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    bcd_to_bin_seq_if #(.DIGITS(3), .OUT_W(8)) bus ();

    bcd_to_bin_seq #(.DIGITS(3), .OUT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef BCD2BIN_SAT_EN
    localparam logic [7:0] EXP_256 = 8'hFF;
    localparam logic [7:0] EXP_999 = 8'hFF;
`else
    localparam logic [7:0] EXP_256 = 8'h00;
    localparam logic [7:0] EXP_999 = 8'hE7;
`endif

    // Present a one-cycle start; returns in cycle k+1 (after accepting edge k).
    task automatic start_conv(input logic [11:0] v);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bcd_in = v;
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    // Bounded wait for done; cyc is the cycle index relative to edge k.
    task automatic wait_done(output int cyc, output int busy_cnt);
        cyc = 1;
        busy_cnt = 0;
        while (bus.done !== 1'b1 && cyc <= 40) begin
            if (bus.busy === 1'b1) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.bcd_in = 12'h000;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({bus.busy, bus.done, bus.ovf, bus.err_digit} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b want 0000", {bus.busy, bus.done, bus.ovf, bus.err_digit});
        end
        tests_run++;
        if (bus.bin_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_bin_out: got %h want 00", bus.bin_out);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_valid();
        logic [11:0] vin  [5] = '{12'h255, 12'h123, 12'h000, 12'h009, 12'h100};
        logic [7:0]  vexp [5] = '{8'hFF, 8'h7B, 8'h00, 8'h09, 8'h64};
        int cyc, bc;
        for (int i = 0; i < 5; i++) begin
            start_conv(vin[i]);
            wait_done(cyc, bc);
            tests_run++;
            if (cyc !== 13) begin
                tests_failed++;
                $display("FAIL valid_latency[%h]: got %0d want 13", vin[i], cyc);
            end
            tests_run++;
            if (bc !== 12) begin
                tests_failed++;
                $display("FAIL valid_busy_cycles[%h]: got %0d want 12", vin[i], bc);
            end
            tests_run++;
            if (bus.bin_out !== vexp[i]) begin
                tests_failed++;
                $display("FAIL valid_bin_out[%h]: got %h want %h", vin[i], bus.bin_out, vexp[i]);
            end
            tests_run++;
            if ({bus.ovf, bus.err_digit, bus.busy} !== 3'b000) begin
                tests_failed++;
                $display("FAIL valid_flags[%h]: got %b want 000", vin[i], {bus.ovf, bus.err_digit, bus.busy});
            end
            tests_run++;
            if (dut.bcd_q !== 12'h000) begin
                tests_failed++;
                $display("FAIL valid_bcd_residue[%h]: got %h want 000", vin[i], dut.bcd_q);
            end
            @(negedge clk);
            tests_run++;
            if (bus.done !== 1'b0 || bus.bin_out !== vexp[i]) begin
                tests_failed++;
                $display("FAIL valid_hold[%h]: got done=%b bin=%h want done=0 bin=%h", vin[i], bus.done, bus.bin_out, vexp[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [11:0] vin  [2] = '{12'h256, 12'h999};
        logic [7:0]  vexp [2] = '{EXP_256, EXP_999};
        int cyc, bc;
        for (int i = 0; i < 2; i++) begin
            start_conv(vin[i]);
            wait_done(cyc, bc);
            tests_run++;
            if (cyc !== 13) begin
                tests_failed++;
                $display("FAIL ovf_latency[%h]: got %0d want 13", vin[i], cyc);
            end
            tests_run++;
            if (bus.bin_out !== vexp[i]) begin
                tests_failed++;
                $display("FAIL ovf_bin_out[%h]: got %h want %h", vin[i], bus.bin_out, vexp[i]);
            end
            tests_run++;
            if (bus.ovf !== 1'b1 || bus.err_digit !== 1'b0) begin
                tests_failed++;
                $display("FAIL ovf_flags[%h]: got ovf=%b err=%b want ovf=1 err=0", vin[i], bus.ovf, bus.err_digit);
            end
            @(negedge clk);
            tests_run++;
            if (bus.ovf !== 1'b1) begin
                tests_failed++;
                $display("FAIL ovf_hold[%h]: got %b want 1", vin[i], bus.ovf);
            end
        end
    endtask

    task automatic test_err_digit();
        int cyc, bc;
        start_conv(12'h1A3);
        wait_done(cyc, bc);
        tests_run++;
        if (cyc !== 1) begin
            tests_failed++;
            $display("FAIL err_latency: got %0d want 1", cyc);
        end
        tests_run++;
        if (bc !== 0) begin
            tests_failed++;
            $display("FAIL err_busy_cycles: got %0d want 0", bc);
        end
        tests_run++;
        if (bus.err_digit !== 1'b1 || bus.ovf !== 1'b0 || bus.bin_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL err_result: got err=%b ovf=%b bin=%h want err=1 ovf=0 bin=00", bus.err_digit, bus.ovf, bus.bin_out);
        end
        @(negedge clk);
        tests_run++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.err_digit !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_hold: got done=%b busy=%b err=%b want 0 0 1", bus.done, bus.busy, bus.err_digit);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bc;
        start_conv(12'h050);
        cyc = 1;
        while (bus.done !== 1'b1 && cyc <= 40) begin
            if (cyc == 5) begin
                bus.start  = 1'b1;
                bus.bcd_in = 12'h200;
            end else if (cyc == 6) begin
                bus.start  = 1'b0;
                bus.bcd_in = 12'h999;
            end
            @(negedge clk);
            cyc++;
        end
        tests_run++;
        if (cyc !== 13) begin
            tests_failed++;
            $display("FAIL ignore_latency: got %0d want 13", cyc);
        end
        tests_run++;
        if (bus.bin_out !== 8'h32 || bus.err_digit !== 1'b0) begin
            tests_failed++;
            $display("FAIL ignore_result: got bin=%h err=%b want bin=32 err=0", bus.bin_out, bus.err_digit);
        end
        // Start presented in the DONE cycle itself.
        bus.start  = 1'b1;
        bus.bcd_in = 12'h007;
        @(negedge clk);
        bus.start  = 1'b0;
        tests_run++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_accept: got busy=%b done=%b want busy=1 done=0", bus.busy, bus.done);
        end
        wait_done(cyc, bc);
        tests_run++;
        if (cyc !== 13 || bus.bin_out !== 8'h07) begin
            tests_failed++;
            $display("FAIL b2b_result: got cyc=%0d bin=%h want cyc=13 bin=07", cyc, bus.bin_out);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int cyc, bc, pulses;
        start_conv(12'h099);
        for (int i = 1; i < 6; i++) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.busy, bus.done, bus.ovf, bus.err_digit} !== 4'b0000 || bus.bin_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL abort_clear: got flags=%b bin=%h want 0000 00", {bus.busy, bus.done, bus.ovf, bus.err_digit}, bus.bin_out);
        end
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done === 1'b1) pulses++;
        end
        rst_n = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
        end
        tests_run++;
        if (pulses !== 0) begin
            tests_failed++;
            $display("FAIL abort_no_done: got %0d activity cycles want 0", pulses);
        end
        start_conv(12'h042);
        wait_done(cyc, bc);
        tests_run++;
        if (cyc !== 13 || bus.bin_out !== 8'h2A || bus.ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_restart: got cyc=%0d bin=%h ovf=%b want 13 2A 0", cyc, bus.bin_out, bus.ovf);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_valid();
        test_overflow();
        test_err_digit();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
